alu_uart_if: RTL and testbench

Sequencing stage between the UART receiver/transmitter and the `alu` block. Collects three serial bytes in order (operand A, operand B, opcode) from the UART RX, presents them as registered operands to the ALU, then latches the ALU result and hands it to the UART TX as one byte. One transaction at a time; bytes that arrive while a result is in flight are dropped and flagged.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_uart_if.sv | 99 +++++++++
 tb/tb_alu_uart_if.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing stage, the ALU and the benches.
package alu_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_CALC    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;

  typedef enum logic [2:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    CALC    = ST_CALC,
    WAIT_TX = ST_WAIT_TX
  } state_e;

  // ALU opcodes (MIPS funct field)
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_if.sv
// Sequencer between UART RX/TX and the ALU: gathers A, B, opcode bytes,
// drives registered operands, then hands the ALU result to the TX as one byte.
module alu_uart_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  input  logic                  tx_done,
  input  logic [DATA_WIDTH-1:0] resultado,
  output logic [DATA_WIDTH-1:0] dato_A,
  output logic [DATA_WIDTH-1:0] dato_B,
  output logic [OP_WIDTH-1:0]   op,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  overrun
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   dato_a_q, dato_a_d;
  logic [DATA_WIDTH-1:0]   dato_b_q, dato_b_d;
  logic [OP_WIDTH-1:0]     op_q, op_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    overrun_q, overrun_d;

  // Next-state and register updates; operands hold until the next transaction
  always_comb begin
    state_d    = state_q;
    dato_a_d   = dato_a_q;
    dato_b_d   = dato_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      WAIT_A: if (rx_done) begin
        dato_a_d = rx_data;
        state_d  = WAIT_B;
      end
      WAIT_B: if (rx_done) begin
        dato_b_d = rx_data;
        state_d  = WAIT_OP;
      end
      WAIT_OP: if (rx_done) begin
        op_d    = rx_data[OP_WIDTH-1:0];
        state_d = CALC;
      end
      CALC: begin
        // ALU has had one full cycle to settle on the new operands
        tx_data_d  = resultado;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
        if (rx_done) overrun_d = 1'b1;
      end
      WAIT_TX: begin
        // A byte arriving here is dropped even if tx_done frees us this cycle
        if (rx_done) overrun_d = 1'b1;
        if (tx_done) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= WAIT_A;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign dato_A   = dato_a_q;
  assign dato_B   = dato_b_q;
  assign op       = op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = (state_q != WAIT_A);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_alu_uart_if.sv
// Scoreboard bench for alu_uart_if with a behavioural ALU peer.
module tb_alu_uart_if;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] resultado;
  logic [7:0] dato_A, dato_B, tx_data;
  logic [5:0] op;
  logic       tx_start, busy, overrun;

  int applied = 0;
  int errs    = 0;
  int edge_n  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    int         edge_no;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_uart_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_done(rx_done),
    .tx_done(tx_done), .resultado(resultado), .dato_A(dato_A), .dato_B(dato_B),
    .op(op), .tx_data(tx_data), .tx_start(tx_start), .busy(busy), .overrun(overrun)
  );

  // Behavioural ALU peer
  always_comb begin
    resultado = 8'h00;
    case (op)
      OP_ADD: resultado = dato_A + dato_B;
      OP_SUB: resultado = dato_A - dato_B;
      OP_AND: resultado = dato_A & dato_B;
      OP_OR:  resultado = dato_A | dato_B;
      OP_XOR: resultado = dato_A ^ dato_B;
      OP_SRA: resultado = $signed(dato_A) >>> dato_B;
      OP_SRL: resultado = dato_A >> dato_B;
      OP_NOR: resultado = ~(dato_A | dato_B);
      default: resultado = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    applied++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: compare every tx_start pulse against the scoreboard head
  initial begin
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(posedge clk); #1;
      edge_n++;
      if (tx_start) begin
        if (prev_start) chk("tx_start_width", 32'd2, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_tx_start", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e.res));
          chk("op", 32'(op), 32'(e.op));
          chk("dato_A", 32'(dato_A), 32'(e.a));
          chk("dato_B", 32'(dato_B), 32'(e.b));
          chk("tx_start_latency", 32'(edge_n), 32'(e.edge_no));
        end
      end
      prev_start = tx_start;
    end
  end

  // Three back-to-back bytes; expectation pushed as the opcode byte is driven
  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                     input logic [7:0] res);
    exp_t e;
    @(negedge clk); rx_done = 1'b1; rx_data = a;
    @(negedge clk); rx_data = b;
    @(negedge clk); rx_data = opb;
    e.a = a; e.b = b; e.op = opb[5:0]; e.res = res; e.edge_no = edge_n + 2;
    exp_q.push_back(e);
    @(negedge clk); rx_done = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send1(input logic [7:0] b);
    @(negedge clk); rx_done = 1'b1; rx_data = b;
    @(negedge clk); rx_done = 1'b0; rx_data = 8'h00;
  endtask

  task automatic pulse_tx_done(input logic with_rx, input logic [7:0] b);
    @(negedge clk); tx_done = 1'b1; rx_done = with_rx; rx_data = b;
    @(negedge clk); tx_done = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
  endtask

  // Bounded wait for the scoreboard to drain
  task automatic wait_drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("tx_start_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dato_A"}, 32'(dato_A), 32'd0);
    chk({tag, "_dato_B"}, 32'(dato_B), 32'd0);
    chk({tag, "_op"}, 32'(op), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // ADD, with a stray tx_done while still collecting operands
    @(negedge clk); rx_done = 1'b1; rx_data = 8'h05;
    @(negedge clk); rx_done = 1'b0; tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    chk("stray_tx_done_busy", 32'(busy), 32'd1);
    chk("stray_tx_done_A", 32'(dato_A), 32'h05);
    begin
      exp_t e;
      @(negedge clk); rx_done = 1'b1; rx_data = 8'h03;
      @(negedge clk); rx_data = 8'h20;
      e.a = 8'h05; e.b = 8'h03; e.op = OP_ADD; e.res = 8'h08; e.edge_no = edge_n + 2;
      exp_q.push_back(e);
      @(negedge clk); rx_done = 1'b0;
    end
    wait_drain();
    chk("add_busy_wait_tx", 32'(busy), 32'd1);
    pulse_tx_done(1'b0, 8'h00);
    chk("add_busy_done", 32'(busy), 32'd0);

    // SUB wraps negative
    txn(8'h03, 8'h05, 8'h22, 8'hFE);
    wait_drain(); pulse_tx_done(1'b0, 8'h00);

    // Upper opcode bits ignored: 0xE5 -> OR
    txn(8'h0F, 8'hF0, 8'hE5, 8'hFF);
    wait_drain(); pulse_tx_done(1'b0, 8'h00);

    // Invalid opcode still transmitted as 0x00
    txn(8'h0F, 8'hF0, 8'h3F, 8'h00);
    wait_drain(); pulse_tx_done(1'b0, 8'h00);
    chk("pre_overrun", 32'(overrun), 32'd0);

    // Overrun during WAIT_TX
    txn(8'h01, 8'h02, 8'h20, 8'h03);
    wait_drain();
    send1(8'h77);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_tx_data", 32'(tx_data), 32'h03);
    chk("ovr_busy", 32'(busy), 32'd1);
    chk("ovr_dato_A", 32'(dato_A), 32'h01);
    pulse_tx_done(1'b0, 8'h00);
    chk("ovr_busy_done", 32'(busy), 32'd0);
    txn(8'h04, 8'h04, 8'h26, 8'h00);
    wait_drain();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    pulse_tx_done(1'b0, 8'h00);

    // Reset mid-transaction
    send1(8'hAA); send1(8'h55);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk_all_zero("midrst");
    txn(8'h02, 8'h01, 8'h24, 8'h00);
    wait_drain();

    // Simultaneous rx_done and tx_done in WAIT_TX
    pulse_tx_done(1'b1, 8'h99);
    chk("sim_busy", 32'(busy), 32'd0);
    chk("sim_overrun", 32'(overrun), 32'd1);
    chk("sim_dato_A", 32'(dato_A), 32'h02);
    txn(8'h09, 8'h01, 8'h20, 8'h0A);
    wait_drain(); pulse_tx_done(1'b0, 8'h00);
    chk("final_busy", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

endmodule
